// File: rtl/spandex_types.sv
// Shared types for the L2 response-plane arbiter.
//   l2_arb_pkt_t      : one coherence packet as carried on the response NoC plane
//   arb_src_t         : which L2 source a granted packet came from
//   L2_RSP_ARB_CNT_W  : width of the optional per-source packet counters
//   cnt_sat_inc()     : saturating increment used by those counters
package spandex_types;

    localparam int L2_RSP_ARB_CNT_W = 16;

    localparam int COH_MSG_W   = 5;
    localparam int REQ_ID_W    = 4;
    localparam int ADDR_W      = 32;
    localparam int LINE_W      = 64;
    localparam int WORD_MASK_W = 4;

    // Message codes used by the responders feeding this block.
    localparam logic [COH_MSG_W-1:0] RSP_DATA = 5'd4;
    localparam logic [COH_MSG_W-1:0] FWD_GETS = 5'd8;

    typedef enum logic {
        ARB_SRC_RSP = 1'b0,
        ARB_SRC_FWD = 1'b1
    } arb_src_t;

    typedef struct packed {
        logic [COH_MSG_W-1:0]   coh_msg;
        logic [REQ_ID_W-1:0]    req_id;
        logic [1:0]             to_req;
        logic [ADDR_W-1:0]      addr;
        logic [LINE_W-1:0]      line;
        logic [WORD_MASK_W-1:0] word_mask;
    } l2_arb_pkt_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [L2_RSP_ARB_CNT_W-1:0] cnt_sat_inc(
        input logic [L2_RSP_ARB_CNT_W-1:0] v
    );
        logic [L2_RSP_ARB_CNT_W-1:0] r;
        if (v == {L2_RSP_ARB_CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + L2_RSP_ARB_CNT_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/l2_rsp_plane_arb_fifo.sv
// Small synchronous FIFO used to buffer one arbiter source.
// Ports:
//   clk, rst         : clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data  : write request; ignored while full
//   pop              : read request; ignored while empty
//   full, empty      : status from registered occupancy
//   head             : oldest entry (valid while !empty)
// DEPTH must be a power of two >= 2 so pointers wrap naturally.
module l2_arb_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [7:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output logic full,
    output logic empty,
    output T     head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    T                 mem_q [DEPTH];
    T                 mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == {CNT_W{1'b0}});
    assign head      = mem_q[rd_ptr_q];
    // Full blocks a push even when a pop frees a slot in the same cycle.
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers; reset discards every buffered entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/l2_rsp_plane_arb.sv
// Merges the L2's response (rsp) and forwarded-data (fwd) streams onto one
// outgoing response NoC plane. Each source is buffered in its own FIFO; a
// single output register holds the granted packet stable until accepted.
// rsp has priority, but after MAX_CONSEC back-to-back rsp grants with fwd
// waiting, fwd is granted once.
// Ports:
//   clk, rst                         : clock, asynchronous active-low reset
//   rsp_valid/rsp_ready/rsp_data     : source 0 (responses to requesters)
//   fwd_valid/fwd_ready/fwd_data     : source 1 (forwarded data)
//   out_valid/out_ready/out_data     : NoC plane handshake and packet
//   out_src                          : 0 = rsp, 1 = fwd
//   idle                             : both FIFOs empty and out_valid low
// Optional build macro L2_RSP_ARB_STATS_EN adds:
//   stats_clr                        : zero both counters next cycle
//   stats_rsp_cnt / stats_fwd_cnt    : saturating accepted-packet counts
module l2_rsp_plane_arb
    import spandex_types::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_CONSEC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    input  l2_arb_pkt_t rsp_data,
    input  logic        fwd_valid,
    output logic        fwd_ready,
    input  l2_arb_pkt_t fwd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output l2_arb_pkt_t out_data,
    output logic        out_src,
    output logic        idle
`ifdef L2_RSP_ARB_STATS_EN
    ,
    input  logic                        stats_clr,
    output logic [L2_RSP_ARB_CNT_W-1:0] stats_rsp_cnt,
    output logic [L2_RSP_ARB_CNT_W-1:0] stats_fwd_cnt
`endif
);

    localparam logic [3:0] MAX_C = 4'(MAX_CONSEC);

    logic        rsp_full_s, rsp_empty_s, rsp_pop_s;
    logic        fwd_full_s, fwd_empty_s, fwd_pop_s;
    l2_arb_pkt_t rsp_head_s, fwd_head_s;
    logic        rsp_has_s, fwd_has_s;
    logic        load_s;
    arb_src_t    grant_s;

    logic        out_valid_q, out_valid_d;
    l2_arb_pkt_t out_data_q, out_data_d;
    arb_src_t    out_src_q, out_src_d;
    logic [3:0]  consec_q, consec_d;

    assign rsp_ready = ~rsp_full_s;
    assign fwd_ready = ~fwd_full_s;
    assign rsp_has_s = ~rsp_empty_s;
    assign fwd_has_s = ~fwd_empty_s;

    l2_arb_fifo #(.DEPTH(FIFO_DEPTH), .T(l2_arb_pkt_t)) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rsp_valid & rsp_ready),
        .push_data (rsp_data),
        .pop       (rsp_pop_s),
        .full      (rsp_full_s),
        .empty     (rsp_empty_s),
        .head      (rsp_head_s)
    );

    l2_arb_fifo #(.DEPTH(FIFO_DEPTH), .T(l2_arb_pkt_t)) u_fwd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fwd_valid & fwd_ready),
        .push_data (fwd_data),
        .pop       (fwd_pop_s),
        .full      (fwd_full_s),
        .empty     (fwd_empty_s),
        .head      (fwd_head_s)
    );

    // The output register can take a new packet when empty or being drained.
    assign load_s    = (~out_valid_q | out_ready) & (rsp_has_s | fwd_has_s);
    assign rsp_pop_s = load_s & (grant_s == ARB_SRC_RSP);
    assign fwd_pop_s = load_s & (grant_s == ARB_SRC_FWD);

    // Source selection: rsp first unless fwd has waited through MAX_CONSEC grants.
    always_comb begin
        grant_s = ARB_SRC_RSP;
        if (rsp_has_s && fwd_has_s) begin
            if (consec_q == MAX_C) begin
                grant_s = ARB_SRC_FWD;
            end else begin
                grant_s = ARB_SRC_RSP;
            end
        end else if (fwd_has_s) begin
            grant_s = ARB_SRC_FWD;
        end else begin
            grant_s = ARB_SRC_RSP;
        end
    end

    // Output register and fairness counter next-state.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        consec_d    = consec_q;
        if (load_s) begin
            out_valid_d = 1'b1;
            out_src_d   = grant_s;
            if (grant_s == ARB_SRC_FWD) begin
                out_data_d = fwd_head_s;
                consec_d   = 4'd0;
            end else begin
                out_data_d = rsp_head_s;
                // Only rsp grants that make fwd wait count against fairness.
                if (fwd_has_s) begin
                    consec_d = (consec_q >= MAX_C) ? MAX_C : (consec_q + 4'd1);
                end else begin
                    consec_d = 4'd0;
                end
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output stage and fairness counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= ARB_SRC_RSP;
            consec_q    <= 4'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            consec_q    <= consec_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign idle      = rsp_empty_s & fwd_empty_s & ~out_valid_q;

`ifdef L2_RSP_ARB_STATS_EN
    logic [L2_RSP_ARB_CNT_W-1:0] stats_rsp_q, stats_rsp_d;
    logic [L2_RSP_ARB_CNT_W-1:0] stats_fwd_q, stats_fwd_d;

    // Per-source accepted-packet counters; clear wins over a same-cycle accept.
    always_comb begin
        stats_rsp_d = stats_rsp_q;
        stats_fwd_d = stats_fwd_q;
        if (stats_clr) begin
            stats_rsp_d = {L2_RSP_ARB_CNT_W{1'b0}};
            stats_fwd_d = {L2_RSP_ARB_CNT_W{1'b0}};
        end else if (out_valid_q && out_ready) begin
            if (out_src_q == ARB_SRC_FWD) begin
                stats_fwd_d = cnt_sat_inc(stats_fwd_q);
            end else begin
                stats_rsp_d = cnt_sat_inc(stats_rsp_q);
            end
        end else begin
            stats_rsp_d = stats_rsp_q;
            stats_fwd_d = stats_fwd_q;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stats_rsp_q <= {L2_RSP_ARB_CNT_W{1'b0}};
            stats_fwd_q <= {L2_RSP_ARB_CNT_W{1'b0}};
        end else begin
            stats_rsp_q <= stats_rsp_d;
            stats_fwd_q <= stats_fwd_d;
        end
    end

    assign stats_rsp_cnt = stats_rsp_q;
    assign stats_fwd_cnt = stats_fwd_q;
`endif

endmodule

// File: doc/l2_rsp_plane_arb.md
Name: l2_rsp_plane_arb

Overview:
- Arbitrates the L2's two coherence-response outputs (responses to requesters, forwarded-data outputs) onto one shared outgoing response NoC plane.
- Sits between l2_core's rsp_out/fwd_out valid/ready ports and the NoC plane interface.
- Buffers each source and applies response-priority arbitration with a fairness cap.
- Drives a registered, stable-until-accepted output.

Parameters:
- FIFO_DEPTH, 2: entries per source buffer; power of 2, >=2.
- MAX_CONSEC, 4: max consecutive rsp grants while fwd is waiting; range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- rsp_valid / rsp_ready  in / out  1 / 1  source 0 handshake
- rsp_data  in  l2_arb_pkt_t  fields: coh_msg, req_id, to_req[1:0], addr, line, word_mask
- fwd_valid / fwd_ready  in / out  1 / 1  source 1 handshake
- fwd_data  in  l2_arb_pkt_t  same fields as rsp_data
- out_valid  out  1  NoC plane valid
- out_ready  in  1  NoC plane ready
- out_data  out  l2_arb_pkt_t  granted packet
- out_src  out  1  0 = rsp, 1 = fwd
- idle  out  1  both FIFOs empty and out_valid = 0

Behaviour:
- Reset (rst = 0, asynchronous): FIFOs empty, out_valid = 0, out_data = 0, out_src = 0, rsp_ready = fwd_ready = 1 (first cycle after release), idle = 1, consec counter = 0. Reset mid-transfer drops all buffered packets; no partial packets survive.
- Input handshake:
  - x_ready = !full, from registered occupancy.
  - A push occurs when x_valid & x_ready.
  - A push is not allowed when the FIFO is full, even if a pop happens in the same cycle.
  - Simultaneous push and pop on a non-full FIFO keeps the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
- Output stage:
  - A single register (out_valid, out_data, out_src).
  - It loads when (!out_valid | out_ready) and at least one FIFO head is valid; otherwise out_valid clears on out_ready.
  - While out_valid & !out_ready, out_data and out_src hold stable.
  - Minimum latency: push in cycle N gives out_valid in cycle N+2. Full-throughput sustained rate is 1 packet/cycle.
- Arbitration, evaluated only when the output stage loads:
  - Only rsp head valid: grant rsp.
  - Only fwd head valid: grant fwd.
  - Both valid: grant rsp unless consec == MAX_CONSEC, in which case grant fwd.
- consec counter (4 bit):
  - Increments on an rsp grant while the fwd head is valid; saturates at MAX_CONSEC.
  - Clears on any fwd grant, or on an rsp grant with the fwd head empty.
- Pop: the granted FIFO pops in the same cycle the output register loads.
- idle is registered-free combinational: all FIFOs empty and out_valid = 0.
- Packet order within one source is preserved; there is no ordering guarantee across sources.

Optional Feature:
- Macro: L2_RSP_ARB_STATS_EN.
- When defined, the following ports are added:
  - stats_clr  in  1
  - stats_rsp_cnt  out  16
  - stats_fwd_cnt  out  16
- Counter behaviour: each counter increments on an accepted output packet (out_valid & out_ready) of its source and saturates at 16'hFFFF. stats_clr = 1 zeroes both counters next cycle and takes priority over an increment. Reset value is 0.
- When not defined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package (spandex_types): l2_arb_pkt_t struct, arb_src_t enum {ARB_SRC_RSP = 0, ARB_SRC_FWD = 1}, L2_RSP_ARB_CNT_W = 16.
- Sub-module l2_arb_fifo: parameterized depth and element type; push/pop/full/empty/head. Instantiated twice.

Test Plan:
- Reset then single rsp push (addr = 0x40, coh_msg = RSP_DATA) in cycle 1, out_ready = 1 -> out_valid = 1 in cycle 3, out_src = 0, out_data matches; idle = 1 in cycle 4.
- Backpressure: out_ready = 0, push 3 rsp packets with FIFO_DEPTH = 2 -> first held stable on the output, next two fill the FIFO, rsp_ready = 0. Release out_ready -> all 3 emerge in order.
- Fairness: both sources continuously valid, MAX_CONSEC = 4, out_ready = 1 -> grant pattern rsp,rsp,rsp,rsp,fwd repeating; fwd never waits more than 4 grants.
- Single-source fwd stream of 8 packets with rsp idle -> 8 consecutive fwd outputs at 1/cycle, consec stays 0.
- Assert rst low while out_valid = 1 and both FIFOs hold 2 entries -> immediately out_valid = 0, idle = 1; after release no stale packet appears.
- With L2_RSP_ARB_STATS_EN: 5 rsp + 3 fwd accepted -> stats_rsp_cnt = 5, stats_fwd_cnt = 3. stats_clr pulse -> both 0. Preload 16'hFFFF -> further grants hold at 16'hFFFF.
